ram_read_scanner: RTL and testbench

- Read-side companion to the 32x4 RAM write path: sweeps the RAM read port through every address, one address per dwell period.
- Accounts for the RAM's registered read latency and presents each address/data pair to the HEX display logic with a valid flag.
- Snoops the write port so a displayed word that is overwritten gets refreshed instead of going stale.
- Sits between ram32x4 (rdaddress/q) and the display_num_on_hex instances, clocked from CLOCK_50.

---
 rtl/ram_read_scanner_if.sv | 28 ++
 rtl/ram_read_scanner.sv | 143 ++++++++++++++
 tb/tb_ram_read_scanner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_read_scanner_if.sv
// Bundle between the read scanner, the RAM read/write ports and the HEX display.
// master: scanner side (drives rdaddress and disp_*); slave: RAM/display/control side.
interface ram_read_scanner_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              enable;
    logic              pause;
    logic              step;
    logic              wren_snoop;
    logic [ADDR_W-1:0] wraddress_snoop;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] rdaddress;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wrap;

    modport master (
        input  enable, pause, step, wren_snoop, wraddress_snoop, q,
        output rdaddress, disp_addr, disp_data, disp_valid, wrap
    );

    modport slave (
        output enable, pause, step, wren_snoop, wraddress_snoop, q,
        input  rdaddress, disp_addr, disp_data, disp_valid, wrap
    );
endinterface

// File: rtl/ram_read_scanner.sv
// Sweeps the RAM read port one address per dwell period and presents each
// address/data pair to the display. Ports: clock, reset (async, high), bus (master).
module ram_read_scanner #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int TICKS  = 50000000,
    parameter int RD_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    ram_read_scanner_if.master bus
);
    localparam int TICK_W = $clog2(TICKS);
    localparam int LAT_W  = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DWELL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              wrap_q, wrap_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic snoop_cur;
    logic snoop_disp;
    logic advance;

    // A write to the address in flight may return stale data; a write to the
    // displayed address makes the shown word stale.
    assign snoop_cur  = bus.wren_snoop && (bus.wraddress_snoop == cur_addr_q);
    assign snoop_disp = bus.wren_snoop && (bus.wraddress_snoop == disp_addr_q);
    assign advance    = bus.step || (!bus.pause && (tick_q == TICK_LAST));

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrap_d       = 1'b0;
        tick_d       = tick_q;
        lat_d        = lat_q;

        if ((state_q != S_IDLE) && !bus.enable) begin
            state_d      = S_IDLE;
            disp_valid_d = 1'b0;
            tick_d       = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.enable) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_d = '0;
                    if (snoop_cur) begin
                        state_d = S_ISSUE;
                    end else if (RD_LAT > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
                S_WAIT: begin
                    if (snoop_cur) begin
                        state_d = S_ISSUE;
                    end else if (lat_q == LAT_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (snoop_cur) begin
                        state_d = S_ISSUE;
                    end else begin
                        disp_addr_d  = cur_addr_q;
                        disp_data_d  = bus.q;
                        disp_valid_d = 1'b1;
                        tick_d       = '0;
                        state_d      = S_DWELL;
                    end
                end
                S_DWELL: begin
                    // Advance outranks a refresh in the same cycle.
                    if (advance) begin
                        cur_addr_d = cur_addr_q + 1'b1;
                        wrap_d     = (cur_addr_q == ADDR_LAST);
                        state_d    = S_ISSUE;
                    end else if (snoop_disp) begin
                        state_d = S_ISSUE;
                    end else if (!bus.pause) begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            tick_q       <= '0;
            lat_q        <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wrap_q       <= wrap_d;
            tick_q       <= tick_d;
            lat_q        <= lat_d;
        end
    end

    assign bus.rdaddress  = cur_addr_q;
    assign bus.disp_addr  = disp_addr_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_ram_read_scanner.sv
// Bench for ram_read_scanner with TICKS=4, RD_LAT=1 and a 32x4 RAM model
// preloaded with mem[k]=k^4'hA.
module tb_ram_read_scanner;
    localparam int TICKS = 4;

    typedef struct packed {
        logic [4:0] a;
        logic [3:0] d;
    } exp_t;

    typedef struct {
        logic       en, pa, st, we;
        logic [4:0] wa;
        logic [3:0] wd;
        int         n;
        logic       ev;
        logic [4:0] ea;
        logic [3:0] ed;
        logic [4:0] er;
    } vec_t;

    logic clk;
    logic rst;
    logic [3:0] wdata;
    logic [3:0] mem [32];
    int   cyc;
    int   total;
    int   passed;
    int   wrap_cnt;
    bit   chk_space;
    exp_t sb[$];
    vec_t ta[2];
    vec_t tc[30];

    ram_read_scanner_if #(.ADDR_W(5), .DATA_W(4)) bus ();

    ram_read_scanner #(
        .ADDR_W(5),
        .DATA_W(4),
        .TICKS (TICKS),
        .RD_LAT(1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read, read-during-write returns the old word.
    always @(posedge clk) begin
        if (bus.wren_snoop) mem[bus.wraddress_snoop] <= wdata;
        bus.q <= mem[bus.rdaddress];
    end

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp);
    endtask

    function automatic vec_t mk(logic en, logic pa, logic st, logic we,
                                logic [4:0] wa, logic [3:0] wd, int n,
                                logic ev, logic [4:0] ea, logic [3:0] ed,
                                logic [4:0] er);
        vec_t v;
        v.en = en; v.pa = pa; v.st = st; v.we = we;
        v.wa = wa; v.wd = wd; v.n = n;
        v.ev = ev; v.ea = ea; v.ed = ed; v.er = er;
        return v;
    endfunction

    task automatic apply(vec_t v, string tag, int idx);
        bus.enable          = v.en;
        bus.pause           = v.pa;
        bus.step            = v.st;
        bus.wren_snoop      = v.we;
        bus.wraddress_snoop = v.wa;
        wdata               = v.wd;
        repeat (v.n) @(posedge clk);
        #2;
        chk($sformatf("%s[%0d].valid", tag, idx), bus.disp_valid, v.ev);
        chk($sformatf("%s[%0d].addr", tag, idx), bus.disp_addr, v.ea);
        chk($sformatf("%s[%0d].data", tag, idx), bus.disp_data, v.ed);
        chk($sformatf("%s[%0d].rdaddr", tag, idx), bus.rdaddress, v.er);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".valid"}, bus.disp_valid, 0);
        chk({tag, ".addr"}, bus.disp_addr, 0);
        chk({tag, ".data"}, bus.disp_data, 0);
        chk({tag, ".rdaddr"}, bus.rdaddress, 0);
        chk({tag, ".wrap"}, bus.wrap, 0);
    endtask

    // Scoreboard monitor: every new displayed pair pops one expectation.
    initial begin
        logic       pv;
        logic [4:0] pa;
        logic [3:0] pd;
        int         last_cyc;
        bit         have_last;
        exp_t       e;
        pv = 1'b0; pa = '0; pd = '0;
        last_cyc = 0; have_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                have_last = 0;
                continue;
            end
            if (bus.wrap) begin
                wrap_cnt++;
                chk("wrap_disp_addr", bus.disp_addr, 31);
            end
            if (bus.disp_valid &&
                (!pv || bus.disp_addr != pa || bus.disp_data != pd)) begin
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_addr", bus.disp_addr, e.a);
                    chk("sb_data", bus.disp_data, e.d);
                end
                if (chk_space && have_last)
                    chk("dwell_spacing", cyc - last_cyc, TICKS + 2);
                last_cyc = cyc;
                have_last = 1;
            end
            pv = bus.disp_valid;
            pa = bus.disp_addr;
            pd = bus.disp_data;
        end
    end

    initial begin
        int c0;
        total = 0; passed = 0; wrap_cnt = 0; chk_space = 0;
        for (int k = 0; k < 32; k++) mem[k] = 4'(k) ^ 4'hA;
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.pause = 1'b0;
        bus.step = 1'b0;
        bus.wren_snoop = 1'b0;
        bus.wraddress_snoop = '0;
        wdata = '0;

        ta[0] = mk(1,0,0,0,0,0,2, 0,0,4'h0,0);
        ta[1] = mk(1,0,0,0,0,0,1, 1,0,4'hA,0);

        tc[0]  = mk(1,1,0,0,0,0,20, 1,5,4'hF,5);
        tc[1]  = mk(1,1,1,0,0,0,1, 1,5,4'hF,6);
        tc[2]  = mk(1,1,0,0,0,0,1, 1,5,4'hF,6);
        tc[3]  = mk(1,1,0,0,0,0,1, 1,6,4'hC,6);
        tc[4]  = mk(1,1,1,0,0,0,1, 1,6,4'hC,7);
        tc[5]  = mk(1,1,1,0,0,0,1, 1,6,4'hC,7);
        tc[6]  = mk(1,1,0,0,0,0,1, 1,7,4'hD,7);
        tc[7]  = mk(1,1,0,0,0,0,6, 1,7,4'hD,7);
        tc[8]  = mk(1,1,0,1,7,3,1, 1,7,4'hD,7);
        tc[9]  = mk(1,1,0,0,0,0,1, 1,7,4'hD,7);
        tc[10] = mk(1,1,0,0,0,0,1, 1,7,4'h3,7);
        tc[11] = mk(1,1,0,1,9,5,1, 1,7,4'h3,7);
        tc[12] = mk(1,1,0,0,0,0,4, 1,7,4'h3,7);
        tc[13] = mk(1,1,1,0,0,0,1, 1,7,4'h3,8);
        tc[14] = mk(1,1,0,0,0,0,2, 1,8,4'h2,8);
        tc[15] = mk(1,1,1,0,0,0,1, 1,8,4'h2,9);
        tc[16] = mk(1,1,0,0,0,0,2, 1,9,4'h5,9);
        tc[17] = mk(1,1,1,0,0,0,1, 1,9,4'h5,10);
        tc[18] = mk(1,1,0,0,0,0,2, 1,10,4'h0,10);
        tc[19] = mk(1,1,1,0,0,0,1, 1,10,4'h0,11);
        tc[20] = mk(1,1,0,0,0,0,2, 1,11,4'h1,11);
        tc[21] = mk(1,1,1,0,0,0,1, 1,11,4'h1,12);
        tc[22] = mk(1,1,0,1,12,9,1, 1,11,4'h1,12);
        tc[23] = mk(1,1,0,0,0,0,1, 1,11,4'h1,12);
        tc[24] = mk(1,1,0,0,0,0,1, 1,12,4'h9,12);
        tc[25] = mk(1,1,1,0,0,0,1, 1,12,4'h9,13);
        tc[26] = mk(0,1,0,0,0,0,1, 0,12,4'h9,13);
        tc[27] = mk(0,1,0,0,0,0,3, 0,12,4'h9,13);
        tc[28] = mk(1,1,0,0,0,0,2, 0,12,4'h9,13);
        tc[29] = mk(1,1,0,0,0,0,1, 1,13,4'h7,13);

        repeat (2) @(posedge clk);
        #2;
        chk_zero("in_reset");

        sb.push_back({5'd0, 4'hA});
        rst = 1'b0;
        for (int i = 0; i < 2; i++) apply(ta[i], "first", i);

        chk_space = 1;
        for (int k = 1; k < 32; k++) sb.push_back({5'(k), 4'(k) ^ 4'hA});
        sb.push_back({5'd0, 4'hA});
        repeat (32 * (TICKS + 2)) @(posedge clk);
        #2;
        chk("sweep_end_addr", bus.disp_addr, 0);
        chk("sweep_wrap_count", wrap_cnt, 1);

        for (int k = 1; k <= 5; k++) sb.push_back({5'(k), 4'(k) ^ 4'hA});
        repeat (4 * (TICKS + 2)) @(posedge clk);
        chk_space = 0;
        repeat (TICKS + 2) @(posedge clk);
        #2;
        chk("sync_addr5", bus.disp_addr, 5);

        sb.push_back({5'd6, 4'hC});
        sb.push_back({5'd7, 4'hD});
        sb.push_back({5'd7, 4'h3});
        sb.push_back({5'd8, 4'h2});
        sb.push_back({5'd9, 4'h5});
        sb.push_back({5'd10, 4'h0});
        sb.push_back({5'd11, 4'h1});
        sb.push_back({5'd12, 4'h9});
        sb.push_back({5'd13, 4'h7});
        for (int i = 0; i < 30; i++) apply(tc[i], "seq", i);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("wrap_total", wrap_cnt, 1);

        c0 = cyc;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        chk("async_rst.no_edge", cyc, c0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
